// File: rtl/alu_result_stage.sv
// Registered output stage for the SimpleALU. A two-entry skid buffer lets in_ready
// come straight from a flop, so the stage still passes one result per cycle.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_result,
    input  logic [OP_W-1:0]  in_opcode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OP_W-1:0]  out_opcode,
    output logic             out_isZero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] result_count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // The producer holds its data while valid is high and ready is low, and the
    // consumer side holds out_* stable in the same situation.
    logic             accept;
    logic             drain;
    logic             in_zero;

    logic [WIDTH-1:0] main_result, main_result_n;
    logic [OP_W-1:0]  main_opcode, main_opcode_n;
    logic             main_zero, main_zero_n;
    logic             main_valid, main_valid_n;

    logic [WIDTH-1:0] skid_result, skid_result_n;
    logic [OP_W-1:0]  skid_opcode, skid_opcode_n;
    logic             skid_zero, skid_zero_n;
    logic             skid_valid, skid_valid_n;

    logic             ready_q, ready_n;
    logic [CNT_W-1:0] count_q, count_n;

    assign accept  = in_valid & ready_q;
    assign drain   = main_valid & out_ready;
    assign in_zero = (in_result == '0);

    always_comb begin
        main_result_n = main_result;
        main_opcode_n = main_opcode;
        main_zero_n   = main_zero;
        main_valid_n  = main_valid;
        skid_result_n = skid_result;
        skid_opcode_n = skid_opcode;
        skid_zero_n   = skid_zero;
        skid_valid_n  = skid_valid;
        count_n       = count_q;

        if (drain) begin
            count_n = count_q + CNT_W'(1);
        end

        if (!main_valid || drain) begin
            if (skid_valid) begin
                // Oldest data lives in skid; promote it before taking anything new.
                main_result_n = skid_result;
                main_opcode_n = skid_opcode;
                main_zero_n   = skid_zero;
                main_valid_n  = 1'b1;
                skid_valid_n  = accept;
                if (accept) begin
                    skid_result_n = in_result;
                    skid_opcode_n = in_opcode;
                    skid_zero_n   = in_zero;
                end
            end else if (accept) begin
                main_result_n = in_result;
                main_opcode_n = in_opcode;
                main_zero_n   = in_zero;
                main_valid_n  = 1'b1;
            end else begin
                main_valid_n  = 1'b0;
            end
        end else if (accept) begin
            skid_result_n = in_result;
            skid_opcode_n = in_opcode;
            skid_zero_n   = in_zero;
            skid_valid_n  = 1'b1;
        end

        ready_n = !skid_valid_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            main_result <= '0;
            main_opcode <= '0;
            main_zero   <= 1'b0;
            main_valid  <= 1'b0;
            skid_result <= '0;
            skid_opcode <= '0;
            skid_zero   <= 1'b0;
            skid_valid  <= 1'b0;
            ready_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            main_result <= main_result_n;
            main_opcode <= main_opcode_n;
            main_zero   <= main_zero_n;
            main_valid  <= main_valid_n;
            skid_result <= skid_result_n;
            skid_opcode <= skid_opcode_n;
            skid_zero   <= skid_zero_n;
            skid_valid  <= skid_valid_n;
            ready_q     <= ready_n;
            count_q     <= count_n;
        end
    end

    assign in_ready     = ready_q;
    assign out_valid    = main_valid;
    assign out_result   = main_result;
    assign out_opcode   = main_opcode;
    assign out_isZero   = main_zero;
    assign result_count = count_q;

endmodule
